// File: rtl/field_cfg_loader.sv
// field_cfg_loader: raster-scans the field-configuration ROM and streams one write beat per cell.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_start                        load request, honoured only while idle
//   o_busy, o_done                 loading / one-cycle completion pulse
//   o_rom_x_adr, o_rom_y_adr       scan counter driving the ROM address
//   i_rom_cell                     ROM cell state for the current scan address
//   o_wr_en, o_wr_x_adr,
//   o_wr_y_adr, o_wr_cell          registered write beat toward the field memory
//   i_wr_ready                     field memory accepts the beat
//   o_live_cnt                     live cells loaded, present only with FIELD_LOADER_POPCNT_EN
module field_cfg_loader #(
    parameter  int FIELD_W    = 64,
    parameter  int FIELD_H    = 48,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H)
`ifdef FIELD_LOADER_POPCNT_EN
    ,
    localparam int CNT_SIZE   = $clog2(FIELD_W * FIELD_H + 1)
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [X_ADR_SIZE-1:0] o_rom_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_rom_y_adr,
    input  logic                  i_rom_cell,
    output logic                  o_wr_en,
    output logic [X_ADR_SIZE-1:0] o_wr_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_wr_y_adr,
    output logic                  o_wr_cell,
`ifdef FIELD_LOADER_POPCNT_EN
    input  logic                  i_wr_ready,
    output logic [CNT_SIZE-1:0]   o_live_cnt
`else
    input  logic                  i_wr_ready
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t                state_q, state_d;
    logic [X_ADR_SIZE-1:0] x_q, x_d, wr_x_q, wr_x_d;
    logic [Y_ADR_SIZE-1:0] y_q, y_d, wr_y_q, wr_y_d;
    logic                  exh_q, exh_d, wr_en_q, wr_en_d, wr_cell_q, wr_cell_d;
    logic                  x_last, y_last, accept, take;
    assign x_last = x_q == X_ADR_SIZE'(FIELD_W - 1);
    assign y_last = y_q == Y_ADR_SIZE'(FIELD_H - 1);
    assign accept = wr_en_q & i_wr_ready;
    // The beat register refills whenever it is empty or being drained, as long as cells remain.
    assign take   = (state_q == LOAD) & (~wr_en_q | i_wr_ready) & ~exh_q;
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        exh_d     = exh_q;
        wr_en_d   = wr_en_q;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_cell_d = wr_cell_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = LOAD;
                x_d     = '0;
                y_d     = '0;
                exh_d   = 1'b0;
            end
            LOAD: begin
                if (accept & exh_q) begin
                    wr_en_d = 1'b0;
                    state_d = DONE;
                end
                if (take) begin
                    wr_en_d   = 1'b1;
                    wr_x_d    = x_q;
                    wr_y_d    = y_q;
                    wr_cell_d = i_rom_cell;
                    // The last cell parks the counter and marks it exhausted instead of wrapping y.
                    exh_d     = x_last & y_last;
                    x_d       = x_last ? (y_last ? x_q : '0) : x_q + 1'b1;
                    y_d       = (x_last & ~y_last) ? y_q + 1'b1 : y_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            exh_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_cell_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            exh_q     <= exh_d;
            wr_en_q   <= wr_en_d;
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            wr_cell_q <= wr_cell_d;
        end
    end
`ifdef FIELD_LOADER_POPCNT_EN
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    assign cnt_d = (state_q == IDLE && i_start) ? '0 : cnt_q + CNT_SIZE'(accept & wr_cell_q);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
    assign o_live_cnt = cnt_q;
`endif
    assign o_busy      = state_q == LOAD;
    assign o_done      = state_q == DONE;
    assign o_rom_x_adr = x_q;
    assign o_rom_y_adr = y_q;
    assign o_wr_en     = wr_en_q;
    assign o_wr_x_adr  = wr_x_q;
    assign o_wr_y_adr  = wr_y_q;
    assign o_wr_cell   = wr_cell_q;
endmodule
